single_ram_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port register RAM between two independent masters, such as a producer and a consumer engine. Each requester uses a valid/ready command port carrying read or write, address and write data. The block grants one access per cycle with round-robin fairness and optional bounded burst locking, and returns registered read data per requester. It instantiates the RAM internally and is the only path to it.

---
 rtl/single_ram_arbiter_pkg.sv | 26 ++
 rtl/single_ram_arbiter_ram.sv | 41 ++++
 rtl/single_ram_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_single_ram_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/single_ram_arbiter_pkg.sv
// Shared constants and helpers for the two-requester RAM arbiter.
package single_ram_arbiter_pkg;

    // Arbiter FSM encoding
    localparam logic [1:0] S_RR    = 2'd0;
    localparam logic [1:0] S_LOCK0 = 2'd1;
    localparam logic [1:0] S_LOCK1 = 2'd2;

    // Requester indices as stored in the last-granted register
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Bits needed to represent value (minimum 1)
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned v;
        int unsigned result;
        v      = value;
        result = 0;
        while (v != 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage

// File: rtl/single_ram_arbiter_ram.sv
// Single-port register RAM: synchronous write, combinational read, async clear.
module single_ram_arbiter_ram #(
    parameter int unsigned P_DATA_WIDTH = 4,
    parameter int unsigned P_ADDR_DEPTH = 128,
    parameter int unsigned P_ADDR_WIDTH = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic                    wea,
    input  logic [P_ADDR_WIDTH-1:0] addr,
    input  logic [P_DATA_WIDTH-1:0] wdata,
    output logic [P_DATA_WIDTH-1:0] rdata_c
);

    logic [P_DATA_WIDTH-1:0] mem [P_ADDR_DEPTH];
    logic                    in_range;

    // Addresses past the last word are legal but map to nothing
    assign in_range = 32'(addr) < P_ADDR_DEPTH;

    // Combinational read; out-of-range words read as zero
    always_comb begin
        rdata_c = '0;
        if (in_range) begin
            rdata_c = mem[addr];
        end
    end

    // Write port with whole-array clear on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < P_ADDR_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (ena && wea && in_range) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/single_ram_arbiter.sv
// Round-robin arbiter with bounded burst locking in front of one shared RAM.
module single_ram_arbiter
    import single_ram_arbiter_pkg::*;
#(
    parameter  int unsigned P_DATA_WIDTH = 4,
    parameter  int unsigned P_ADDR_DEPTH = 128,
    parameter  int unsigned P_MAX_BURST  = 8,
    localparam int unsigned P_ADDR_WIDTH = clogb2(P_ADDR_DEPTH - 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_req0_valid,
    input  logic                    i_req0_wr,
    input  logic                    i_req0_lock,
    input  logic [P_ADDR_WIDTH-1:0] i_req0_addr,
    input  logic [P_DATA_WIDTH-1:0] i_req0_wdata,
    output logic                    o_req0_ready,
    output logic                    o_req0_rvalid,
    output logic [P_DATA_WIDTH-1:0] o_req0_rdata,
    input  logic                    i_req1_valid,
    input  logic                    i_req1_wr,
    input  logic                    i_req1_lock,
    input  logic [P_ADDR_WIDTH-1:0] i_req1_addr,
    input  logic [P_DATA_WIDTH-1:0] i_req1_wdata,
    output logic                    o_req1_ready,
    output logic                    o_req1_rvalid,
    output logic [P_DATA_WIDTH-1:0] o_req1_rdata
);

    localparam int unsigned CNT_W = clogb2(P_MAX_BURST);

    logic [1:0]              state, state_n;
    logic                    r_last, last_n;
    logic [CNT_W-1:0]        r_burst_cnt, cnt_n;
    logic                    grant0, grant1;
    logic                    ram_ena, ram_wea;
    logic [P_ADDR_WIDTH-1:0] ram_addr;
    logic [P_DATA_WIDTH-1:0] ram_wdata, ram_rdata_c;

    // Grant selection: lock owner first, otherwise round-robin
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        case (state)
            S_LOCK0: begin
                grant0 = i_req0_valid;
                grant1 = ~i_req0_valid & i_req1_valid;
            end
            S_LOCK1: begin
                grant1 = i_req1_valid;
                grant0 = ~i_req1_valid & i_req0_valid;
            end
            default: begin
                if (i_req0_valid && i_req1_valid) begin
                    grant0 = (r_last == REQ1);
                    grant1 = (r_last == REQ0);
                end else begin
                    grant0 = i_req0_valid;
                    grant1 = i_req1_valid;
                end
            end
        endcase
        if (i_rst) begin
            grant0 = 1'b0;
            grant1 = 1'b0;
        end
    end

    assign o_req0_ready = grant0;
    assign o_req1_ready = grant1;

    // Next-state, fairness pointer and burst counter
    always_comb begin
        state_n = state;
        last_n  = r_last;
        cnt_n   = r_burst_cnt;
        case (state)
            S_LOCK0: begin
                if (!i_req0_valid) begin
                    state_n = S_RR;
                    last_n  = REQ0;
                    cnt_n   = '0;
                end else begin
                    cnt_n = r_burst_cnt + CNT_W'(1);
                    if (!i_req0_lock || cnt_n == CNT_W'(P_MAX_BURST)) begin
                        state_n = S_RR;
                        last_n  = REQ0;
                        cnt_n   = '0;
                    end
                end
            end
            S_LOCK1: begin
                if (!i_req1_valid) begin
                    state_n = S_RR;
                    last_n  = REQ1;
                    cnt_n   = '0;
                end else begin
                    cnt_n = r_burst_cnt + CNT_W'(1);
                    if (!i_req1_lock || cnt_n == CNT_W'(P_MAX_BURST)) begin
                        state_n = S_RR;
                        last_n  = REQ1;
                        cnt_n   = '0;
                    end
                end
            end
            default: begin
                state_n = S_RR;
                cnt_n   = '0;
                if (grant0) begin
                    last_n = REQ0;
                    if (i_req0_lock && P_MAX_BURST > 1) begin
                        state_n = S_LOCK0;
                        cnt_n   = CNT_W'(1);
                    end
                end else if (grant1) begin
                    last_n = REQ1;
                    if (i_req1_lock && P_MAX_BURST > 1) begin
                        state_n = S_LOCK1;
                        cnt_n   = CNT_W'(1);
                    end
                end
            end
        endcase
    end

    // Arbiter state registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_RR;
            r_last      <= REQ1;
            r_burst_cnt <= '0;
        end else begin
            state       <= state_n;
            r_last      <= last_n;
            r_burst_cnt <= cnt_n;
        end
    end

    // RAM command mux from the granted requester
    always_comb begin
        ram_ena   = grant0 | grant1;
        ram_wea   = grant0 ? i_req0_wr    : (grant1 & i_req1_wr);
        ram_addr  = grant0 ? i_req0_addr  : i_req1_addr;
        ram_wdata = grant0 ? i_req0_wdata : i_req1_wdata;
    end

    single_ram_arbiter_ram #(
        .P_DATA_WIDTH(P_DATA_WIDTH),
        .P_ADDR_DEPTH(P_ADDR_DEPTH),
        .P_ADDR_WIDTH(P_ADDR_WIDTH)
    ) u_ram (
        .clk    (i_clk),
        .rst    (i_rst),
        .ena    (ram_ena),
        .wea    (ram_wea),
        .addr   (ram_addr),
        .wdata  (ram_wdata),
        .rdata_c(ram_rdata_c)
    );

    // Per-requester read return, captured at the accepting edge
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_req0_rvalid <= 1'b0;
            o_req0_rdata  <= '0;
            o_req1_rvalid <= 1'b0;
            o_req1_rdata  <= '0;
        end else begin
            o_req0_rvalid <= grant0 & ~i_req0_wr;
            o_req1_rvalid <= grant1 & ~i_req1_wr;
            if (grant0 && !i_req0_wr) begin
                o_req0_rdata <= ram_rdata_c;
            end
            if (grant1 && !i_req1_wr) begin
                o_req1_rdata <= ram_rdata_c;
            end
        end
    end

endmodule

// File: tb/tb_single_ram_arbiter.sv
// Directed scoreboard bench for single_ram_arbiter (default and depth-100 builds).
module tb_single_ram_arbiter;
    import single_ram_arbiter_pkg::*;

    localparam int unsigned DW    = 4;
    localparam int unsigned DEPTH = 128;
    localparam int unsigned AW    = 7;
    localparam int unsigned MB    = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default-parameter DUT
    logic          v0, wr0, lk0, v1, wr1, lk1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic          rdy0, rv0, rdy1, rv1;
    logic [DW-1:0] rd0, rd1;

    single_ram_arbiter #(.P_DATA_WIDTH(DW), .P_ADDR_DEPTH(DEPTH), .P_MAX_BURST(MB)) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(v0), .i_req0_wr(wr0), .i_req0_lock(lk0), .i_req0_addr(a0), .i_req0_wdata(d0),
        .o_req0_ready(rdy0), .o_req0_rvalid(rv0), .o_req0_rdata(rd0),
        .i_req1_valid(v1), .i_req1_wr(wr1), .i_req1_lock(lk1), .i_req1_addr(a1), .i_req1_wdata(d1),
        .o_req1_ready(rdy1), .o_req1_rvalid(rv1), .o_req1_rdata(rd1)
    );

    // Non-power-of-two depth DUT
    logic          b_v0, b_wr0, b_lk0, b_v1, b_wr1, b_lk1;
    logic [AW-1:0] b_a0, b_a1;
    logic [DW-1:0] b_d0, b_d1;
    logic          b_rdy0, b_rv0, b_rdy1, b_rv1;
    logic [DW-1:0] b_rd0, b_rd1;

    single_ram_arbiter #(.P_DATA_WIDTH(DW), .P_ADDR_DEPTH(100), .P_MAX_BURST(MB)) u_dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(b_v0), .i_req0_wr(b_wr0), .i_req0_lock(b_lk0), .i_req0_addr(b_a0), .i_req0_wdata(b_d0),
        .o_req0_ready(b_rdy0), .o_req0_rvalid(b_rv0), .o_req0_rdata(b_rd0),
        .i_req1_valid(b_v1), .i_req1_wr(b_wr1), .i_req1_lock(b_lk1), .i_req1_addr(b_a1), .i_req1_wdata(b_d1),
        .o_req1_ready(b_rdy1), .o_req1_rvalid(b_rv1), .o_req1_rdata(b_rd1)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] sb0[$];
    logic [DW-1:0] sb1[$];
    logic          pend0, pend1;
    logic [DW-1:0] last0, last1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle on the default DUT: check grants and read returns, then score the new beat
    task automatic step(input logic e0, input logic e1);
        @(negedge clk);
        check("ready0", 32'(rdy0), 32'(e0));
        check("ready1", 32'(rdy1), 32'(e1));
        check("rvalid0", 32'(rv0), 32'(pend0));
        check("rvalid1", 32'(rv1), 32'(pend1));
        if (pend0 && sb0.size() > 0) last0 = sb0.pop_front();
        if (pend1 && sb1.size() > 0) last1 = sb1.pop_front();
        check("rdata0", 32'(rd0), 32'(last0));
        check("rdata1", 32'(rd1), 32'(last1));
        pend0 = 1'b0;
        pend1 = 1'b0;
        if (e0 && v0) begin
            if (wr0) model[a0] = d0;
            else begin sb0.push_back(model[a0]); pend0 = 1'b1; end
        end else if (e1 && v1) begin
            if (wr1) model[a1] = d1;
            else begin sb1.push_back(model[a1]); pend1 = 1'b1; end
        end
        @(posedge clk);
        #1;
    endtask

    // One accepted beat on requester 0 of the depth-100 DUT
    task automatic b_beat(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        b_v0 = 1'b1; b_wr0 = wr; b_a0 = addr; b_d0 = data;
        @(negedge clk);
        check("b_ready0", 32'(b_rdy0), 32'd1);
        @(posedge clk);
        #1;
        b_v0 = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
        sb0.delete();
        sb1.delete();
        pend0 = 1'b0;
        pend1 = 1'b0;
        last0 = '0;
        last1 = '0;
    endtask

    initial begin
        int            exp_g [14];
        logic [AW-1:0] rd_addrs [6];
        int            n0;

        exp_g    = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        rd_addrs = '{7'd126, 7'd0, 7'd5, 7'd10, 7'd21, 7'd20};

        v0 = 0; wr0 = 0; lk0 = 0; a0 = '0; d0 = '0;
        v1 = 0; wr1 = 0; lk1 = 0; a1 = '0; d1 = '0;
        b_v0 = 0; b_wr0 = 0; b_lk0 = 0; b_a0 = '0; b_d0 = '0;
        b_v1 = 0; b_wr1 = 0; b_lk1 = 0; b_a1 = '0; b_d1 = '0;
        clear_model();

        // Reset: ready held low even with valid asserted
        rst = 1'b1;
        v0  = 1'b1;
        #3;
        check("rst_ready0", 32'(rdy0), 32'd0);
        check("rst_rvalid0", 32'(rv0), 32'd0);
        check("rst_rdata0", 32'(rd0), 32'd0);
        v0 = 1'b0;
        #19 rst = 1'b0;
        @(posedge clk);
        #1;

        // T1: write then read back on req0
        v0 = 1; wr0 = 1; a0 = 7'd5; d0 = 4'hA;
        step(1, 0);
        wr0 = 0;
        step(1, 0);
        v0 = 0;
        step(0, 0);
        step(0, 0);

        // req1 writes so that req0 wins the next contention
        v1 = 1; wr1 = 1; a1 = 7'd2; d1 = 4'h6;
        step(0, 1);

        // T2: continuous reads from both, strict alternation starting with req0
        v0 = 1; wr0 = 0; a0 = 7'd1;
        v1 = 1; wr1 = 0; a1 = 7'd2;
        for (int i = 0; i < 6; i++) step(i % 2 == 0, i % 2 == 1);

        // T3: 12 locked writes from req0 against a constantly valid req1.
        // Burst caps at 8, req1 gets one beat, then req0 re-locks for its last 4.
        n0 = 0;
        for (int c = 0; c < 14; c++) begin
            v0 = (n0 < 12); wr0 = 1; lk0 = 1; a0 = AW'(10 + n0); d0 = DW'(n0);
            v1 = 1; wr1 = 0; a1 = 7'd2;
            step(v0 && exp_g[c] == 0, exp_g[c] == 1);
            if (v0 && exp_g[c] == 0) n0++;
        end
        v0 = 0; v1 = 0; lk0 = 0;
        step(0, 0);

        // T4: lock lost while req1 waits; req1 granted same cycle, FSM back to round-robin
        v0 = 1; wr0 = 1; lk0 = 1; a0 = 7'd20; d0 = 4'h5;
        step(1, 0);
        v0 = 0; v1 = 1; wr1 = 0; a1 = 7'd2;
        step(0, 1);
        v0 = 1; lk0 = 0;
        step(0, 1);
        step(1, 0);
        v0 = 0; v1 = 0;
        step(0, 0);

        // T5: top address written by req1, read by req0 next cycle; neighbours untouched
        v1 = 1; wr1 = 1; a1 = 7'd127; d1 = 4'h3;
        step(0, 1);
        v1 = 0; v0 = 1; wr0 = 0; a0 = 7'd127;
        step(1, 0);
        for (int i = 0; i < 6; i++) begin
            a0 = rd_addrs[i];
            step(1, 0);
        end
        v0 = 0;
        step(0, 0);

        // T6: reset lands on an accepted read
        v0 = 1; wr0 = 0; a0 = 7'd5;
        @(negedge clk);
        check("pre_rst_ready0", 32'(rdy0), 32'd1);
        rst = 1'b1;
        #1;
        check("in_rst_ready0", 32'(rdy0), 32'd0);
        @(posedge clk);
        #1;
        check("in_rst_rvalid0", 32'(rv0), 32'd0);
        check("in_rst_rdata0", 32'(rd0), 32'd0);
        rst = 1'b0;
        clear_model();
        a0 = 7'd5;
        step(1, 0);
        a0 = 7'd127;
        step(1, 0);
        a0 = 7'd20;
        step(1, 0);
        v0 = 0;
        step(0, 0);

        // Depth 100: out-of-range write suppressed, out-of-range read gives 0
        b_beat(1'b1, 7'd110, 4'hF);
        b_beat(1'b1, 7'd99, 4'h9);
        b_beat(1'b0, 7'd99, 4'h0);
        @(negedge clk);
        check("b_rvalid_99", 32'(b_rv0), 32'd1);
        check("b_rdata_99", 32'(b_rd0), 32'h9);
        @(posedge clk);
        #1;
        b_beat(1'b0, 7'd110, 4'h0);
        @(negedge clk);
        check("b_rvalid_110", 32'(b_rv0), 32'd1);
        check("b_rdata_110", 32'(b_rd0), 32'h0);
        check("b_ready1_idle", 32'(b_rdy1), 32'd0);
        check("b_rvalid1_idle", 32'(b_rv1), 32'd0);
        check("b_rdata1_idle", 32'(b_rd1), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("b_rvalid_pulse", 32'(b_rv0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
